random_chk: RTL and testbench
=============================

RANDOM_CHK -- requirements
Module: random_chk

Interface
REQ-001 The block SHALL have a parameter LOSS_THRESH, default 4, meaning consecutive mismatching samples in TRACK that force a return to HUNT (legal 1..15).
REQ-002 clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 in_valid  input  1  qualifies in_data for one sample per asserted cycle.
REQ-005 in_data  input  7  received sample of the 21-bit LFSR stream: taps at bits 20 and 17, shift-left, new bit entering at bit 0, and the low 7 state bits presented.
REQ-006 locked  output  1  high while in TRACK.
REQ-007 err  output  1  one-cycle pulse on a mismatching sample in TRACK.
REQ-008 err_cnt  output  16  saturating mismatch count; present only when RANDOM_CHK_ERRCNT_EN is defined.

Function
REQ-009 The block SHALL keep a 21-bit history H of in_data[0] across successive valid samples, plus the previous valid sample P.
REQ-010 Predicted sample: {P[5:0], H[20]^H[17]}, where H[20] is bit 0 of the sample 21 back and H[17] is bit 0 of the sample 18 back.
REQ-011 The FSM SHALL have two states: HUNT (reset state) and TRACK.
REQ-012 HUNT:
- every valid sample shifts in_data[0] into H and updates P;
- a fill counter (0..21) increments on each valid sample when in_data[6:1]==P[5:0];
- otherwise the fill counter loads 1.
REQ-013 HUNT->TRACK SHALL occur on the valid sample that brings the fill counter to 21, unless the resulting H is all zeros; then the counter loads 1 and the state stays in HUNT.
REQ-014 TRACK:
- each valid sample is compared with the prediction;
- H and P always advance with the predicted value, never the received one, so errors do not corrupt the reference.
REQ-015 On a TRACK mismatch:
- err SHALL pulse in the cycle after the sample;
- the consecutive-miss counter increments;
- a match clears the consecutive-miss counter.
REQ-016 When the consecutive-miss counter reaches LOSS_THRESH, the block SHALL:
- enter HUNT in the next cycle with locked low;
- set the fill counter to 1 and load H/P from the current received sample.
REQ-017 All outputs SHALL be registered, with one-cycle latency from the valid sample; cycles without in_valid SHALL change no state, and err SHALL be low in them.
REQ-018 The first sample in TRACK is the sample after the locking sample; locked SHALL rise in the cycle after the locking sample.

Reset
REQ-019 While rst is high:
- state SHALL be HUNT;
- H, P, fill counter and miss counter SHALL be 0;
- locked, err and err_cnt SHALL be 0.
REQ-020 A reset asserted mid-operation (in HUNT or TRACK) SHALL abandon lock immediately, with no err pulse.

Configuration
REQ-021 When RANDOM_CHK_ERRCNT_EN is defined:
- err_cnt SHALL increment on every err pulse and saturate at 16'hFFFF;
- err_cnt clears only on reset, not on loss of lock.
REQ-022 When RANDOM_CHK_ERRCNT_EN is undefined, the err_cnt port and its logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-023 The shared package flappy_pkg SHALL hold LFSR_W=21, LFSR_TAP_A=20, LFSR_TAP_B=17, RAND_OUT_W=7, and the FSM state enum.
REQ-024 One sub-module, random_chk_hist, SHALL hold H, P and the prediction logic.
REQ-025 FSM and counters SHALL live in random_chk.

Verification
REQ-026 Source LFSR seeded all-ones, in_valid every cycle -> locked rises in the cycle after the 21st sample; err stays 0 for 1000 samples.
REQ-027 In TRACK, invert in_data[0] on one sample -> exactly one err pulse; locked stays 1; err_cnt=1 with the macro defined.
REQ-028 In TRACK, corrupt 4 consecutive samples (LOSS_THRESH=4) -> 4 err pulses, then locked=0; a clean stream re-locks after 21 valid samples.
REQ-029 All-zero input for 50 samples -> locked stays 0 and err stays 0.
REQ-030 in_valid toggling 1/0 on a valid stream -> locks after 21 valid samples (42 cycles); idle cycles change nothing.
REQ-031 rst pulsed mid-TRACK -> locked=0 and err_cnt=0 asynchronously; re-lock after 21 valid samples.

Source files
------------

// File: rtl/flappy_pkg.sv
// Shared constants and FSM state type for the random_chk LFSR stream checker.
package flappy_pkg;

    localparam int unsigned LFSR_W     = 21;
    localparam int unsigned LFSR_TAP_A = 20;
    localparam int unsigned LFSR_TAP_B = 17;
    localparam int unsigned RAND_OUT_W = 7;

    // Fill counter spans 0..LFSR_W; miss counter spans 0..15.
    localparam int unsigned FILL_W = 5;
    localparam int unsigned MISS_W = 4;

    typedef enum logic [0:0] {
        StHunt  = 1'b0,
        StTrack = 1'b1
    } chk_state_e;

endpackage

// File: rtl/random_chk_hist.sv
// Bit-0 history H, previous sample P and next-sample prediction for random_chk.
module random_chk_hist
    import flappy_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  adv_i,       // advance H/P this cycle
    input  logic                  use_pred_i,  // advance with prediction instead of data_i
    input  logic [RAND_OUT_W-1:0] data_i,
    output logic [RAND_OUT_W-1:0] pred_o,
    output logic                  match_o,     // data_i equals prediction
    output logic                  cont_o,      // data_i is a one-step shift of P
    output logic                  rx_zero_o    // H after shifting in data_i[0] is all zeros
);

    logic [LFSR_W-1:0]     hist_q, hist_d;
    logic [RAND_OUT_W-1:0] prev_q, prev_d;
    logic [LFSR_W-1:0]     hist_rx;

    assign pred_o    = {prev_q[RAND_OUT_W-2:0], hist_q[LFSR_TAP_A] ^ hist_q[LFSR_TAP_B]};
    assign match_o   = (data_i == pred_o);
    assign cont_o    = (data_i[RAND_OUT_W-1:1] == prev_q[RAND_OUT_W-2:0]);
    assign hist_rx   = {hist_q[LFSR_W-2:0], data_i[0]};
    assign rx_zero_o = (hist_rx == '0);

    // Next H/P: shift in either the received or the predicted sample.
    always_comb begin
        hist_d = hist_q;
        prev_d = prev_q;
        if (adv_i) begin
            if (use_pred_i) begin
                hist_d = {hist_q[LFSR_W-2:0], pred_o[0]};
                prev_d = pred_o;
            end else begin
                hist_d = hist_rx;
                prev_d = data_i;
            end
        end
    end

    // History registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hist_q <= '0;
            prev_q <= '0;
        end else begin
            hist_q <= hist_d;
            prev_q <= prev_d;
        end
    end

endmodule

// File: rtl/random_chk.sv
// LFSR stream checker: hunts for lock on a 21-bit LFSR sample stream, then tracks it
// and flags mismatches. Optional saturating error counter under RANDOM_CHK_ERRCNT_EN.
module random_chk
    import flappy_pkg::*;
#(
    parameter int unsigned LOSS_THRESH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [RAND_OUT_W-1:0] in_data,
    output logic                  locked,
`ifdef RANDOM_CHK_ERRCNT_EN
    output logic [15:0]           err_cnt,
`endif
    output logic                  err
);

    localparam logic [FILL_W-1:0] FillLast = FILL_W'(LFSR_W - 1);
    localparam logic [MISS_W-1:0] MissLast = MISS_W'(LOSS_THRESH - 1);

    chk_state_e        state_q, state_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic [MISS_W-1:0] miss_q, miss_d;
    logic              locked_q, locked_d;
    logic              err_q, err_d;

    logic [RAND_OUT_W-1:0] pred;
    logic match, cont, rx_zero;
    logic lose, use_pred;

    // A mismatch that exhausts the miss budget drops lock and reseeds from the received sample.
    assign lose     = (state_q == StTrack) && in_valid && !match && (miss_q == MissLast);
    assign use_pred = (state_q == StTrack) && !lose;

    random_chk_hist u_hist (
        .clk_i      (clk),
        .rst_i      (rst),
        .adv_i      (in_valid),
        .use_pred_i (use_pred),
        .data_i     (in_data),
        .pred_o     (pred),
        .match_o    (match),
        .cont_o     (cont),
        .rx_zero_o  (rx_zero)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= StHunt;
        else     state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StHunt:  if (in_valid && cont && (fill_q == FillLast) && !rx_zero) state_d = StTrack;
            StTrack: if (lose) state_d = StHunt;
            default: state_d = StHunt;
        endcase
    end

    // Output decode, registered below for one-cycle latency.
    always_comb begin
        err_d    = (state_q == StTrack) && in_valid && !match;
        locked_d = (state_d == StTrack);
    end

    // Fill and consecutive-miss counters.
    always_comb begin
        fill_d = fill_q;
        miss_d = miss_q;
        if (in_valid) begin
            unique case (state_q)
                StHunt: begin
                    if (cont && !((fill_q == FillLast) && rx_zero)) fill_d = fill_q + 1'b1;
                    else                                             fill_d = FILL_W'(1);
                end
                StTrack: begin
                    if (match) begin
                        miss_d = '0;
                    end else if (lose) begin
                        miss_d = '0;
                        fill_d = FILL_W'(1);
                    end else begin
                        miss_d = miss_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Counter and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fill_q   <= '0;
            miss_q   <= '0;
            locked_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            fill_q   <= fill_d;
            miss_q   <= miss_d;
            locked_q <= locked_d;
            err_q    <= err_d;
        end
    end

    assign locked = locked_q;
    assign err    = err_q;

`ifdef RANDOM_CHK_ERRCNT_EN
    logic [15:0] err_cnt_q, err_cnt_d;

    // Saturating error count; survives loss of lock, cleared only by reset.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_d && (err_cnt_q != 16'hFFFF)) err_cnt_d = err_cnt_q + 16'd1;
    end

    // Error counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) err_cnt_q <= '0;
        else     err_cnt_q <= err_cnt_d;
    end

    assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_random_chk.sv
// Self-checking bench for random_chk: behavioural model plus directed scenarios and random run.
module tb_random_chk;

    localparam int LOSS = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [6:0] in_data;
    logic       locked;
    logic       err;
`ifdef RANDOM_CHK_ERRCNT_EN
    logic [15:0] err_cnt;
`endif

    random_chk #(.LOSS_THRESH(LOSS)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data  (in_data),
        .locked   (locked),
`ifdef RANDOM_CHK_ERRCNT_EN
        .err_cnt  (err_cnt),
`endif
        .err      (err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // ---------------- behavioural model ----------------
    bit         hbits[$];   // received/predicted bit-0 history, oldest first
    bit         m_track;
    int         m_fill, m_miss;
    logic [6:0] m_prev;
    bit         e_locked, e_err;
    int         e_cnt;

    task automatic model_reset();
        hbits.delete();
        for (int i = 0; i < 21; i++) hbits.push_back(1'b0);
        m_track = 0; m_fill = 0; m_miss = 0; m_prev = '0;
        e_locked = 0; e_err = 0; e_cnt = 0;
    endtask

    function automatic bit hb(input int k);  // bit 0 of the sample k back
        return hbits[hbits.size() - k];
    endfunction

    task automatic push_bit(input bit b);
        hbits.push_back(b);
        void'(hbits.pop_front());
    endtask

    task automatic model_step(input bit v, input logic [6:0] d);
        logic [6:0] pred;
        int ones;
        e_err = 0;
        if (rst) begin
            model_reset();
        end else if (v) begin
            if (!m_track) begin
                push_bit(d[0]);
                ones = 0;
                foreach (hbits[i]) ones += int'(hbits[i]);
                m_fill = (d[6:1] == m_prev[5:0]) ? m_fill + 1 : 1;
                if (m_fill == 21) begin
                    if (ones == 0) m_fill = 1;
                    else           m_track = 1;
                end
                m_prev = d;
            end else begin
                pred = {m_prev[5:0], hb(21) ^ hb(18)};
                if (d == pred) begin
                    m_miss = 0;
                    push_bit(pred[0]);
                    m_prev = pred;
                end else begin
                    e_err = 1;
                    if (e_cnt < 65535) e_cnt++;
                    m_miss++;
                    if (m_miss == LOSS) begin
                        m_track = 0; m_miss = 0; m_fill = 1;
                        push_bit(d[0]);
                        m_prev = d;
                    end else begin
                        push_bit(pred[0]);
                        m_prev = pred;
                    end
                end
            end
            e_locked = m_track;
        end
    endtask

    // Compare DUT with model every cycle, away from the active edge.
    always @(negedge clk) begin
        chk("cyc_locked", int'(locked), int'(e_locked));
        chk("cyc_err", int'(err), int'(e_err));
`ifdef RANDOM_CHK_ERRCNT_EN
        chk("cyc_err_cnt", int'(err_cnt), e_cnt);
`endif
    end

    // ---------------- stimulus ----------------
    logic [20:0] src;
    int          errs;

    function automatic logic [20:0] lfsr_next(input logic [20:0] s);
        return {s[19:0], s[20] ^ s[17]};
    endfunction

    task automatic step(input bit v, input logic [6:0] d);
        in_valid = v;
        in_data  = d;
        @(posedge clk);
        model_step(v, d);
        #2;
        if (err) errs++;
    endtask

    // Send one cycle; when valid, the next LFSR sample XOR mask.
    task automatic send(input bit v, input logic [6:0] mask);
        if (v) begin
            step(1'b1, src[6:0] ^ mask);
            src = lfsr_next(src);
        end else begin
            step(1'b0, $urandom_range(0, 127));
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        repeat (2) step(1'b0, '0);
        rst = 1'b0;
        src = '1;
        errs = 0;
    endtask

    // Feed clean valid samples until lock; n = samples used, or -1 if bound expires.
    task automatic lock_count(output int n);
        n = -1;
        for (int i = 1; i <= 200; i++) begin
            send(1'b1, '0);
            if (locked) begin n = i; break; end
        end
    endtask

    initial begin
        int n;
        rst = 1'b1; in_valid = 1'b0; in_data = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #2;
        chk("reset_locked", int'(locked), 0);
        chk("reset_err", int'(err), 0);
`ifdef RANDOM_CHK_ERRCNT_EN
        chk("reset_err_cnt", int'(err_cnt), 0);
`endif
        rst = 1'b0;
        src = '1;
        errs = 0;

        // Lock on the 21st sample, then clean tracking.
        for (int i = 0; i < 20; i++) send(1'b1, '0);
        chk("lock_after_20", int'(locked), 0);
        send(1'b1, '0);
        chk("lock_after_21", int'(locked), 1);
        for (int i = 0; i < 1000; i++) send(1'b1, '0);
        chk("clean_1000_errs", errs, 0);
        chk("clean_1000_locked", int'(locked), 1);

        // Single corrupted sample.
        errs = 0;
        send(1'b1, 7'h01);
        for (int i = 0; i < 5; i++) send(1'b1, '0);
        chk("single_err_pulses", errs, 1);
        chk("single_locked", int'(locked), 1);
`ifdef RANDOM_CHK_ERRCNT_EN
        chk("single_err_cnt", int'(err_cnt), 1);
`endif

        // Four consecutive corruptions -> loss of lock, then re-lock.
        errs = 0;
        for (int i = 0; i < 3; i++) send(1'b1, 7'h01);
        chk("loss_locked_after_3", int'(locked), 1);
        send(1'b1, 7'h01);
        chk("loss_locked_after_4", int'(locked), 0);
        lock_count(n);
        chk("loss_err_pulses", errs, 4);
        chk("relock_samples", n, 21);
`ifdef RANDOM_CHK_ERRCNT_EN
        chk("loss_err_cnt", int'(err_cnt), 5);
`endif

        // All-zero input never locks.
        do_reset();
        n = 0;
        for (int i = 0; i < 50; i++) begin
            step(1'b1, '0);
            if (locked) n++;
        end
        chk("zero_locked_cycles", n, 0);
        chk("zero_errs", errs, 0);

        // Alternating valid: idle first, lock after 42 cycles.
        do_reset();
        n = -1;
        for (int c = 1; c <= 100; c++) begin
            send(c % 2 == 0, '0);
            if (locked) begin n = c; break; end
        end
        chk("toggle_lock_cycles", n, 42);

        // Async reset mid-TRACK, then re-lock.
        for (int i = 0; i < 10; i++) send(1'b1, 7'h01 & 7'($urandom_range(0, 1)));
        #1;
        rst = 1'b1;
        model_reset();
        #1;
        chk("async_rst_locked", int'(locked), 0);
        chk("async_rst_err", int'(err), 0);
`ifdef RANDOM_CHK_ERRCNT_EN
        chk("async_rst_err_cnt", int'(err_cnt), 0);
`endif
        step(1'b0, '0);
        rst = 1'b0;
        src = '1;
        lock_count(n);
        chk("rst_relock_samples", n, 21);

        // Randomized traffic: sparse valid, occasional error bursts and junk.
        for (int i = 0; i < 4000; i++) begin
            logic [6:0] mask;
            bit v;
            v = ($urandom_range(0, 9) < 7);
            mask = '0;
            if ($urandom_range(0, 99) < 4) mask = 7'($urandom_range(1, 127));
            if ((i % 500) >= 480) mask = 7'($urandom_range(1, 127));
            send(v, mask);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
